// File: rtl/spi_av_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_av_writer                                                   |
// | Purpose  : Avalon-MM write side of SpeedSPI: TX FIFO feeding the engine.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module spi_av_writer #(
   parameter logic [1:0] OFFSET = 2'd0,
   parameter int         DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        avs_s0_write,
   input  logic        avs_s0_read,
   input  logic [15:0] avs_s0_address,
   input  logic [31:0] avs_s0_writedata,
   output logic [31:0] avs_s0_readdata,
   output logic        write_start,
   output logic [7:0]  write_data,
   input  logic        write_done
);
   localparam int                 c_PTR_W     = $clog2(DEPTH);
   localparam logic [3:0]         c_DEPTH_CNT = 4'(DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t             r_state;
   logic [7:0]         r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [3:0]         r_count;
   logic               r_overflow;
   logic [31:0]        r_readdata;
   logic               r_write_start;
   logic [7:0]         r_write_data;

   logic        w_hit;
   logic        w_wr_byte;
   logic        w_wr_ctrl;
   logic        w_rd_status;
   logic        w_full;
   logic        w_empty;
   logic        w_busy;
   logic        w_flush;
   logic        w_ovf_clr;
   logic        w_push;
   logic        w_pop;
   logic [31:0] w_status;
   logic        w_unused;

   assign w_hit       = (avs_s0_address[15:3] == {10'b0, OFFSET, 1'b0});
   assign w_wr_byte   = avs_s0_write & w_hit & (avs_s0_address[2:0] == 3'h1);
   assign w_wr_ctrl   = avs_s0_write & w_hit & (avs_s0_address[2:0] == 3'h4);
   assign w_rd_status = avs_s0_read  & w_hit & (avs_s0_address[2:0] == 3'h3);

   assign w_full    = (r_count == c_DEPTH_CNT);
   assign w_empty   = (r_count == 4'd0);
   assign w_busy    = (r_state != ST_IDLE) | ~w_empty;
   assign w_flush   = w_wr_ctrl & avs_s0_writedata[1];
   assign w_ovf_clr = w_wr_ctrl & avs_s0_writedata[0];
   // Fullness is judged before this edge, so a pop on the same edge never rescues a push.
   assign w_push    = w_wr_byte & ~w_full & ~w_flush;
   assign w_pop     = (r_state == ST_IDLE) & ~w_empty;
   assign w_status  = {24'b0, r_count, r_overflow, w_full, w_empty, w_busy};
   assign w_unused  = ^avs_s0_writedata[31:8];

   assign avs_s0_readdata = r_readdata;
   assign write_start     = r_write_start;
   assign write_data      = r_write_data;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= avs_s0_writedata[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= 4'd0;
         r_overflow    <= 1'b0;
         r_readdata    <= 32'd0;
         r_write_start <= 1'b0;
         r_write_data  <= 8'd0;
      end else begin
         r_readdata <= w_rd_status ? w_status : 32'd0;

         if (w_wr_byte && w_full)
            r_overflow <= 1'b1;
         else if (w_ovf_clr)
            r_overflow <= 1'b0;

         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
         end else begin
            if (w_push)
               r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count <= r_count + {3'b0, w_push} - {3'b0, w_pop};
         end

         // A flush does not cancel the byte already handed to the engine.
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_write_data  <= r_mem[r_rd_ptr];
                  r_write_start <= 1'b1;
                  r_state       <= ST_START;
               end
            end
            ST_START: begin
               r_write_start <= 1'b0;
               r_state       <= ST_WAIT;
            end
            ST_WAIT: begin
               if (write_done)
                  r_state <= ST_IDLE;
            end
            default: begin
               r_write_start <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_spi_av_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_av_writer                                                |
// | Purpose  : Scoreboard bench for spi_av_writer with a simple engine model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_spi_av_writer;
   logic        clk;
   logic        rst;
   logic        avs_write;
   logic        avs_read;
   logic [15:0] avs_addr;
   logic [31:0] avs_wdata;
   logic [31:0] avs_rdata;
   logic        write_start;
   logic [7:0]  write_data;
   logic        write_done;

   logic        w2, r2, done2, ws2;
   logic [15:0] a2;
   logic [31:0] d2, rdata2;
   logic [7:0]  wd2;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd_exp [$];
   logic [7:0]  tx_exp [$];
   logic        rd_seen = 1'b0;
   logic        ws_prev = 1'b0;
   logic [7:0]  last_tx = 8'd0;
   logic        stall = 1'b0;
   logic        chk_done = 1'b1;

   spi_av_writer u_dut (
      .clk              (clk),
      .rst              (rst),
      .avs_s0_write     (avs_write),
      .avs_s0_read      (avs_read),
      .avs_s0_address   (avs_addr),
      .avs_s0_writedata (avs_wdata),
      .avs_s0_readdata  (avs_rdata),
      .write_start      (write_start),
      .write_data       (write_data),
      .write_done       (write_done)
   );

   spi_av_writer #(.OFFSET(2'd1), .DEPTH(4)) u_dut2 (
      .clk              (clk),
      .rst              (rst),
      .avs_s0_write     (w2),
      .avs_s0_read      (r2),
      .avs_s0_address   (a2),
      .avs_s0_writedata (d2),
      .avs_s0_readdata  (rdata2),
      .write_start      (ws2),
      .write_data       (wd2),
      .write_done       (done2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      avs_write = 1'b1;
      avs_addr  = a;
      avs_wdata = d;
      step(1);
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [31:0] e);
      rd_exp.push_back(e);
      avs_read = 1'b1;
      avs_addr = a;
      step(1);
      avs_read = 1'b0;
   endtask

   // Let the stalled engine finish; optionally push on the very edge of the next pop.
   task automatic release_pop(input logic do_push, input logic [7:0] d);
      stall = 1'b0;
      step(2);
      if (do_push)
         wr(16'h0001, {24'b0, d});
      else
         step(1);
      stall = 1'b1;
   endtask

   // Engine model: completes each byte a few cycles after write_start unless stalled.
   initial begin
      write_done = 1'b0;
      forever begin
         @(negedge clk);
         if (write_start) begin
            repeat (2) @(posedge clk);
            while (stall) @(posedge clk);
            #1 write_done = 1'b1;
            @(posedge clk);
            #1 write_done = 1'b0;
         end
      end
   end

   always @(posedge clk) rd_seen <= avs_read;

   initial begin
      forever begin
         @(negedge clk);
         if (rd_seen) begin
            if (rd_exp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_extra: got 0x%08h expected no read data", avs_rdata);
            end else begin
               check("readdata", avs_rdata, rd_exp.pop_front());
            end
         end else begin
            check("rd_idle", avs_rdata, 32'd0);
         end
         if (write_start) begin
            check("ws_width", {31'b0, ws_prev}, 32'd0);
            if (tx_exp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_extra: got byte 0x%02h expected no write_start", write_data);
            end else begin
               check("tx_data", {24'b0, write_data}, {24'b0, tx_exp.pop_front()});
            end
            last_tx = write_data;
         end
         ws_prev = write_start;
         if (write_done && chk_done)
            check("data_hold", {24'b0, write_data}, {24'b0, last_tx});
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      avs_write = 1'b0; avs_read = 1'b0; avs_addr = 16'd0; avs_wdata = 32'd0;
      w2 = 1'b0; r2 = 1'b0; done2 = 1'b0; a2 = 16'd0; d2 = 32'd0;
      rst = 1'b1;
      #2 rst = 1'b0;
      step(3);
      rst = 1'b1;
      check("rst_readdata", avs_rdata, 32'd0);
      check("rst_ws", {31'b0, write_start}, 32'd0);
      check("rst_wd", {24'b0, write_data}, 32'd0);
      rd(16'h0003, 32'h02);

      // Single byte
      tx_exp.push_back(8'hA5);
      wr(16'h0001, 32'h0000_00A5);
      rd(16'h0003, 32'h11);
      rd(16'h0003, 32'h03);
      rd(16'h0003, 32'h03);
      step(10);
      rd(16'h0003, 32'h02);

      // Fill and overflow with the engine stalled
      stall = 1'b1;
      for (int i = 1; i <= 5; i++) tx_exp.push_back(8'(i));
      for (int i = 1; i <= 6; i++) wr(16'h0001, 32'(i));
      rd(16'h0003, 32'h4D);
      stall = 1'b0;
      step(60);
      rd(16'h0003, 32'h0A);
      wr(16'h0004, 32'h1);
      rd(16'h0003, 32'h02);

      // Push coinciding with a pop: dropped when full, neutral at count 2
      stall = 1'b1;
      foreach (tx_exp[i]) ;
      tx_exp.push_back(8'h11); tx_exp.push_back(8'h12); tx_exp.push_back(8'h13);
      tx_exp.push_back(8'h14); tx_exp.push_back(8'h15); tx_exp.push_back(8'h17);
      for (int i = 0; i < 5; i++) wr(16'h0001, 32'h11 + 32'(i));
      step(4);
      release_pop(1'b1, 8'h16);
      rd(16'h0003, 32'h39);
      step(4);
      release_pop(1'b0, 8'h00);
      step(4);
      release_pop(1'b1, 8'h17);
      rd(16'h0003, 32'h29);
      stall = 1'b0;
      step(60);
      rd(16'h0003, 32'h0A);
      wr(16'h0004, 32'h1);
      rd(16'h0003, 32'h02);

      // Flush while a byte is in flight
      stall = 1'b1;
      tx_exp.push_back(8'h21);
      for (int i = 0; i < 4; i++) wr(16'h0001, 32'h21 + 32'(i));
      step(4);
      wr(16'h0004, 32'h2);
      rd(16'h0003, 32'h03);
      stall = 1'b0;
      step(30);
      rd(16'h0003, 32'h02);

      // Address decode on the default bank
      wr(16'h0011, 32'h55);
      wr(16'h0002, 32'h66);
      step(3);
      rd(16'h0003, 32'h02);
      rd(16'h0001, 32'h0);
      rd(16'h0013, 32'h0);

      // Second bank instance
      w2 = 1'b1; a2 = 16'h0001; d2 = 32'h77;
      step(1);
      w2 = 1'b0;
      step(1);
      check("dec_ignore_ws", {31'b0, ws2}, 32'd0);
      r2 = 1'b1; a2 = 16'h0013;
      step(1);
      r2 = 1'b0;
      check("dec_status", rdata2, 32'h02);
      w2 = 1'b1; a2 = 16'h0011; d2 = 32'h88;
      step(1);
      w2 = 1'b0;
      step(1);
      check("dec_accept_ws", {31'b0, ws2}, 32'd1);
      check("dec_accept_wd", {24'b0, wd2}, 32'h88);
      step(1);
      check("dec_ws_drop", {31'b0, ws2}, 32'd0);
      done2 = 1'b1; step(1); done2 = 1'b0;
      step(1);
      done2 = 1'b1; step(1); done2 = 1'b0;
      r2 = 1'b1; a2 = 16'h0013;
      step(1);
      r2 = 1'b0;
      check("stray_done_status", rdata2, 32'h02);
      check("stray_done_wd", {24'b0, wd2}, 32'h88);
      check("stray_done_ws", {31'b0, ws2}, 32'd0);
      r2 = 1'b1; a2 = 16'h0003;
      step(1);
      r2 = 1'b0;
      check("dec_other_bank", rdata2, 32'h0);

      // Asynchronous reset mid-WAIT with bytes queued
      chk_done = 1'b0;
      stall = 1'b1;
      tx_exp.push_back(8'h31);
      for (int i = 0; i < 4; i++) wr(16'h0001, 32'h31 + 32'(i));
      step(4);
      rst = 1'b0;
      #1;
      check("rst_mid_ws", {31'b0, write_start}, 32'd0);
      check("rst_mid_wd", {24'b0, write_data}, 32'd0);
      step(2);
      rst = 1'b1;
      stall = 1'b0;
      step(10);
      rd(16'h0003, 32'h02);
      step(3);

      check("tx_left", 32'(tx_exp.size()), 32'd0);
      check("rd_left", 32'(rd_exp.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
